// File: rtl/rv_decode_pkg.sv
// Shared opcode constants, immediate-kind codes and the decoded bundle type
// used by the immediate decode stage and its combinational selector.
package rv_decode_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [2:0] KIND_R = 3'd0;
  localparam logic [2:0] KIND_I = 3'd1;
  localparam logic [2:0] KIND_S = 3'd2;
  localparam logic [2:0] KIND_B = 3'd3;
  localparam logic [2:0] KIND_U = 3'd4;
  localparam logic [2:0] KIND_J = 3'd5;

  typedef struct packed {
    logic [11:0] imm12;
    logic [2:0]  kind;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/rv_imm12_select.sv
// Combinational decode of one instruction word into the bundle carried
// through the stage: 12-bit immediate field, format kind and register fields.
module rv_imm12_select
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output dec_t            dec
);

  always_comb begin
    dec         = '0;
    dec.opcode  = instr[6:0];
    dec.funct3  = instr[14:12];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.pc      = pc;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: begin
        dec.imm12 = instr[31:20];
        dec.kind  = KIND_I;
      end
      STORE: begin
        dec.imm12 = {instr[31:25], instr[11:7]};
        dec.kind  = KIND_S;
      end
      // Branch offset bits [12:1]; the consumer restores bit 0.
      BRANCH: begin
        dec.imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
        dec.kind  = KIND_B;
      end
      OP:          dec.kind = KIND_R;
      LUI, AUIPC:  dec.kind = KIND_U;
      JAL:         dec.kind = KIND_J;
      default:     dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_imm_decode_stage.sv
// Fetch-to-execute decode stage: registered output bundle behind a
// valid/ready handshake with a one-entry skid buffer and flush.
module rv_imm_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     out_imm12,
  output logic [2:0]      out_imm_kind,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  dec_t dec, main_q, skid_q;
  logic main_v, skid_v;
  logic acc, drain;

  rv_imm12_select #(.XLEN(XLEN)) u_sel (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign in_ready = !skid_v;
  assign acc      = in_valid & in_ready & rst_n & !flush;
  assign drain    = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Skid contents are discarded, never promoted, even if main drains.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || drain) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= acc;
        if (acc) skid_q <= dec;
      end else begin
        main_v <= acc;
        if (acc) main_q <= dec;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid    = main_v;
  assign out_imm12    = main_q.imm12;
  assign out_imm_kind = main_q.kind;
  assign out_opcode   = main_q.opcode;
  assign out_funct3   = main_q.funct3;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_pc       = main_q.pc;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_rv_imm_decode_stage.sv
// Self-checking bench: literal vector table for decode values plus a
// scoreboard queue tracking what the stage must present each cycle.
module tb_rv_imm_decode_stage;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_imm12;
  logic [2:0]  out_imm_kind;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;
  dec_t sb[$];

  always #5 clk = ~clk;

  rv_imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm12(out_imm12), .out_imm_kind(out_imm_kind), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  // Reference decode: format chosen first, immediate gathered bit by bit.
  function automatic dec_t ref_dec(input logic [31:0] w, input logic [31:0] p);
    dec_t d;
    logic [2:0] k;
    logic ill;
    ill = 1'b0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: k = 3'd1;
      7'h23:               k = 3'd2;
      7'h63:               k = 3'd3;
      7'h33:               k = 3'd0;
      7'h37, 7'h17:        k = 3'd4;
      7'h6F:               k = 3'd5;
      default: begin k = 3'd0; ill = 1'b1; end
    endcase
    d = '0;
    for (int b = 0; b < 12; b++) begin
      if (k == 3'd1) d.imm12[b] = w[20+b];
      if (k == 3'd2) d.imm12[b] = (b < 5) ? w[7+b] : w[20+b];
      if (k == 3'd3) begin
        if (b < 4)       d.imm12[b] = w[8+b];
        else if (b < 10) d.imm12[b] = w[21+b];
        else if (b == 10) d.imm12[b] = w[7];
        else             d.imm12[b] = w[31];
      end
    end
    d.kind = k; d.illegal = ill; d.opcode = w[6:0]; d.funct3 = w[14:12];
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.pc = p;
    return d;
  endfunction

  function automatic dec_t actual();
    dec_t a;
    a.imm12 = out_imm12; a.kind = out_imm_kind; a.opcode = out_opcode;
    a.funct3 = out_funct3; a.rd = out_rd; a.rs1 = out_rs1; a.rs2 = out_rs2;
    a.pc = out_pc; a.illegal = out_illegal;
    return a;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " out_valid"}, 80'(out_valid), 80'(sb.size() > 0));
    chk({tag, " in_ready"}, 80'(in_ready), 80'(sb.size() < 2));
    if (sb.size() > 0) chk({tag, " bundle"}, 80'(actual()), 80'(sb[0]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] p,
                     input logic ordy, input logic fl, input string tag);
    logic acc, drn;
    in_valid = v; in_instr = w; in_pc = p; out_ready = ordy; flush = fl;
    acc = v && (sb.size() < 2) && rst_n && !fl;
    drn = (sb.size() > 0) && ordy;
    @(posedge clk);
    if (!rst_n || fl) sb.delete();
    else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back(ref_dec(w, p));
    end
    #1;
    check_state(tag);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [11:0] imm;
    logic [2:0]  kind;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] pool[10];

  initial begin
    vecs[0] = '{32'hFFF00093, 32'h100, 12'hFFF, 3'd1, 1'b0, 5'd1};  // addi x1,x0,-1
    vecs[1] = '{32'hFE112E23, 32'h104, 12'hFFC, 3'd2, 1'b0, 5'd28}; // sw x1,-4(x2)
    vecs[2] = '{32'hFE000EE3, 32'h108, 12'hFFE, 3'd3, 1'b0, 5'd29}; // beq x0,x0,-4
    vecs[3] = '{32'h0000007F, 32'h10C, 12'h000, 3'd0, 1'b1, 5'd0};  // illegal
    vecs[4] = '{32'h000010B7, 32'h110, 12'h000, 3'd4, 1'b0, 5'd1};  // lui x1,1
    vecs[5] = '{32'h002081B3, 32'h114, 12'h000, 3'd0, 1'b0, 5'd3};  // add x3,x1,x2
    vecs[6] = '{32'h0000006F, 32'h118, 12'h000, 3'd5, 1'b0, 5'd0};  // jal x0,0
    vecs[7] = '{32'hFFC12083, 32'h11C, 12'hFFC, 3'd1, 1'b0, 5'd1};  // lw x1,-4(x2)
    for (int i = 0; i < 8; i++) pool[i] = vecs[i].instr;
    pool[8] = 32'h7FF58513; pool[9] = 32'h80A0A463;

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    cyc(1, 32'hFFF00093, 32'h40, 1, 0, "reset");
    cyc(0, 0, 0, 1, 0, "reset");
    chk("reset data", 80'(actual()), 80'(0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(1, vecs[i].instr, vecs[i].pc, 1, 0, "vec");
      chk("vec imm12", 80'(out_imm12), 80'(vecs[i].imm));
      chk("vec kind", 80'(out_imm_kind), 80'(vecs[i].kind));
      chk("vec illegal", 80'(out_illegal), 80'(vecs[i].ill));
      chk("vec rd", 80'(out_rd), 80'(vecs[i].rd));
      chk("vec pc", 80'(out_pc), 80'(vecs[i].pc));
    end
    cyc(0, 0, 0, 1, 0, "idle");

    // Back-pressure: third instruction must wait until the skid drains.
    cyc(1, 32'h00100093, 32'h200, 0, 0, "bp");
    cyc(1, 32'h00200113, 32'h204, 0, 0, "bp");
    chk("bp in_ready low", 80'(in_ready), 80'(0));
    cyc(1, 32'h00300193, 32'h208, 0, 0, "bp");
    cyc(1, 32'h00300193, 32'h208, 0, 0, "bp");
    chk("bp held pc", 80'(out_pc), 80'(32'h200));
    cyc(0, 0, 0, 1, 0, "bp drain");
    chk("bp second pc", 80'(out_pc), 80'(32'h204));
    cyc(1, 32'h00300193, 32'h208, 1, 0, "bp drain");
    cyc(0, 0, 0, 1, 0, "bp drain");
    chk("bp third pc", 80'(out_pc), 80'(32'h208));
    cyc(0, 0, 0, 1, 0, "bp drain");

    // Flush with both entries full and a new input offered.
    cyc(1, 32'h00100093, 32'h300, 0, 0, "fl");
    cyc(1, 32'h00200113, 32'h304, 0, 0, "fl");
    cyc(1, 32'h00400213, 32'h308, 1, 1, "fl");
    chk("flush out_valid", 80'(out_valid), 80'(0));
    chk("flush in_ready", 80'(in_ready), 80'(1));
    cyc(0, 0, 0, 1, 0, "fl after");

    // Reset during a stalled stream, then normal traffic.
    cyc(1, 32'hFE112E23, 32'h400, 0, 0, "rst");
    cyc(1, 32'hFE000EE3, 32'h404, 0, 0, "rst");
    rst_n = 1'b0;
    cyc(1, 32'hFFF00093, 32'h408, 0, 0, "rst");
    chk("midreset data", 80'(actual()), 80'(0));
    rst_n = 1'b1;
    cyc(1, 32'hFFF00093, 32'h40C, 1, 0, "rst after");
    chk("after reset imm", 80'(out_imm12), 80'(12'hFFF));

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w;
      w = pool[$urandom_range(0, 9)] ^ {$urandom_range(0, 32'h1FFFFFF), 7'd0};
      cyc(1'($urandom_range(0, 3) != 0), w, 32'(n) << 2,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
